// File: rtl/epl_row_access_ctrl.sv
// Row access sequencer for one FeRAM row in the EPLFFRAM02 macro.
// It accepts a read or write request, latches the row address and steps the
// array through the WL_ON, PLATE, SENSE, RESTORE and PRECH phases. Reads skip
// nothing and write back the sensed data. Writes skip PLATE and SENSE and
// restore external data. All outputs come straight from flops.
module epl_row_access_ctrl #(
  parameter int ROW_AW = 3,
  parameter int T_WL   = 2,
  parameter int T_PL   = 3,
  parameter int T_SA   = 2,
  parameter int T_RS   = 3,
  parameter int T_PC   = 2,
  parameter int CNT_W  = 4
) (
  input  logic              pClk_i,
  input  logic              pRst_n_i,
  input  logic              pReq_i,
  input  logic              pWe_i,
  input  logic [ROW_AW-1:0] pAr_i,
  output logic              pAck_o,
  output logic              pBusy_o,
  output logic [ROW_AW-1:0] pArLat_o,
  output logic              pWlEn_o,
  output logic              pPlEn_o,
  output logic              pSaEn_o,
  output logic              pWbEn_o,
  output logic              pDinSel_o,
  output logic              pRdVld_o,
  output logic              pDone_o
);

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // The counter must be able to hold the longest phase reload value.
  localparam int T_MAX = max2(max2(max2(T_WL, T_PL), max2(T_SA, T_RS)), T_PC);

  // A zero-length phase or a too-narrow counter is a configuration error.
  localparam bit PARAMS_OK = (T_WL >= 1) && (T_PL >= 1) && (T_SA >= 1) &&
                             (T_RS >= 1) && (T_PC >= 1) &&
                             ((T_MAX - 1) < (2 ** CNT_W));

  // Reload values: a phase of length T occupies counter values T-1 down to 0.
  localparam logic [CNT_W-1:0] LD_WL = CNT_W'(T_WL - 1);
  localparam logic [CNT_W-1:0] LD_PL = CNT_W'(T_PL - 1);
  localparam logic [CNT_W-1:0] LD_SA = CNT_W'(T_SA - 1);
  localparam logic [CNT_W-1:0] LD_RS = CNT_W'(T_RS - 1);
  localparam logic [CNT_W-1:0] LD_PC = CNT_W'(T_PC - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_WL_ON   = 3'd1,
    S_PLATE   = 3'd2,
    S_SENSE   = 3'd3,
    S_RESTORE = 3'd4,
    S_PRECH   = 3'd5
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [ROW_AW-1:0]   ar_q, ar_d;
  logic                accept;

  logic                ack_q;
  logic                busy_q;
  logic                wl_q;
  logic                pl_q;
  logic                sa_q;
  logic                wb_q;
  logic                din_q;
  logic                rdvld_q;
  logic                done_q;

  // Next-state logic: accept in IDLE, otherwise count down and hop phases.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    ar_d    = ar_q;
    accept  = 1'b0;
    if (state_q == S_IDLE) begin
      if (pReq_i) begin
        accept  = 1'b1;
        state_d = S_WL_ON;
        cnt_d   = LD_WL;
        we_d    = pWe_i;
        ar_d    = pAr_i;
      end
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end else begin
      case (state_q)
        S_WL_ON: begin
          // Writes do not need the destructive read, so go straight to restore.
          if (we_q) begin
            state_d = S_RESTORE;
            cnt_d   = LD_RS;
          end else begin
            state_d = S_PLATE;
            cnt_d   = LD_PL;
          end
        end
        S_PLATE: begin
          state_d = S_SENSE;
          cnt_d   = LD_SA;
        end
        S_SENSE: begin
          state_d = S_RESTORE;
          cnt_d   = LD_RS;
        end
        S_RESTORE: begin
          state_d = S_PRECH;
          cnt_d   = LD_PC;
        end
        S_PRECH: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // FSM registers plus outputs decoded from the next state, so every output is a flop.
  always_ff @(posedge pClk_i or negedge pRst_n_i) begin
    if (!pRst_n_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      ar_q    <= '0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
      wl_q    <= 1'b0;
      pl_q    <= 1'b0;
      sa_q    <= 1'b0;
      wb_q    <= 1'b0;
      din_q   <= 1'b0;
      rdvld_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      ar_q    <= ar_d;
      ack_q   <= accept;
      busy_q  <= (state_d != S_IDLE);
      wl_q    <= (state_d inside {S_WL_ON, S_PLATE, S_SENSE, S_RESTORE});
      pl_q    <= (state_d == S_PLATE);
      // Sense amps stay on through restore to hold the sensed levels.
      sa_q    <= (state_d inside {S_SENSE, S_RESTORE});
      wb_q    <= (state_d == S_RESTORE);
      din_q   <= (state_d == S_RESTORE) && we_d;
      rdvld_q <= (state_d == S_SENSE) && (cnt_d == '0);
      done_q  <= (state_q == S_PRECH) && (cnt_q == '0);
    end
  end

  assign pAck_o    = ack_q;
  assign pBusy_o   = busy_q;
  assign pArLat_o  = ar_q;
  assign pWlEn_o   = wl_q;
  assign pPlEn_o   = pl_q;
  assign pSaEn_o   = sa_q;
  assign pWbEn_o   = wb_q;
  assign pDinSel_o = din_q;
  assign pRdVld_o  = rdvld_q;
  assign pDone_o   = done_q;

  a_params_legal: assert property (@(posedge pClk_i) PARAMS_OK)
    else $error("epl_row_access_ctrl: phase length of 0 or CNT_W too small");

endmodule

// File: tb/tb_epl_row_access_ctrl.sv
// Bench for epl_row_access_ctrl: a default-timing instance and an all-ones
// timing instance, checked every cycle against an access-position model, plus
// literal expectations on phase lengths, pulse positions and back-to-back spacing.
module tb_epl_row_access_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [1:0] req, we;
  logic [2:0] ar_in [2];
  logic [1:0] ack, busy, wl, pl, sa, wb, din, rdvld, done;
  logic [2:0] arlat [2];

  epl_row_access_ctrl #(
    .ROW_AW(3), .T_WL(2), .T_PL(3), .T_SA(2), .T_RS(3), .T_PC(2), .CNT_W(4)
  ) u_dut_def (
    .pClk_i(clk), .pRst_n_i(rst_n), .pReq_i(req[0]), .pWe_i(we[0]), .pAr_i(ar_in[0]),
    .pAck_o(ack[0]), .pBusy_o(busy[0]), .pArLat_o(arlat[0]), .pWlEn_o(wl[0]),
    .pPlEn_o(pl[0]), .pSaEn_o(sa[0]), .pWbEn_o(wb[0]), .pDinSel_o(din[0]),
    .pRdVld_o(rdvld[0]), .pDone_o(done[0])
  );

  epl_row_access_ctrl #(
    .ROW_AW(3), .T_WL(1), .T_PL(1), .T_SA(1), .T_RS(1), .T_PC(1), .CNT_W(4)
  ) u_dut_one (
    .pClk_i(clk), .pRst_n_i(rst_n), .pReq_i(req[1]), .pWe_i(we[1]), .pAr_i(ar_in[1]),
    .pAck_o(ack[1]), .pBusy_o(busy[1]), .pArLat_o(arlat[1]), .pWlEn_o(wl[1]),
    .pPlEn_o(pl[1]), .pSaEn_o(sa[1]), .pWbEn_o(wb[1]), .pDinSel_o(din[1]),
    .pRdVld_o(rdvld[1]), .pDone_o(done[1])
  );

  // Phase lengths per instance, order WL, PL, SA, RS, PC
  int tl [2][5] = '{'{2, 3, 2, 3, 2}, '{1, 1, 1, 1, 1}};

  int checks = 0;
  int passes = 0;
  bit chk_en = 1'b0;

  // Model: position inside the current access (0 = idle, 1..len = busy cycle)
  int         m_pos  [2];
  logic       m_we   [2];
  logic [2:0] m_ar   [2];
  logic       m_ack  [2];
  logic       m_done [2];

  function automatic int acc_len(input int i, input logic w);
    if (w) return tl[i][0] + tl[i][3] + tl[i][4];
    return tl[i][0] + tl[i][1] + tl[i][2] + tl[i][3] + tl[i][4];
  endfunction

  // Expected {ack,busy,ar,wl,pl,sa,wb,din,rdvld,done} from the model position
  function automatic logic [11:0] expect_vec(input int i);
    int order [5];
    int n, acc, ph;
    logic last;
    logic [11:0] v;
    if (m_we[i]) begin order = '{0, 3, 4, 0, 0}; n = 3; end
    else         begin order = '{0, 1, 2, 3, 4}; n = 5; end
    acc = 0; ph = -1; last = 1'b0;
    for (int k = 0; k < n; k++) begin
      if (m_pos[i] > acc && m_pos[i] <= acc + tl[i][order[k]]) begin
        ph = order[k];
        last = (m_pos[i] == acc + tl[i][order[k]]);
      end
      acc += tl[i][order[k]];
    end
    v = {m_ack[i], (m_pos[i] != 0), m_ar[i],
         (ph >= 0 && ph <= 3), (ph == 1), (ph == 2 || ph == 3), (ph == 3),
         (ph == 3 && m_we[i]), (ph == 2 && last), m_done[i]};
    return v;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        m_pos[i] <= 0; m_we[i] <= 1'b0; m_ar[i] <= 3'd0;
        m_ack[i] <= 1'b0; m_done[i] <= 1'b0;
      end else begin
        m_ack[i]  <= 1'b0;
        m_done[i] <= 1'b0;
        if (m_pos[i] == 0) begin
          if (req[i]) begin
            m_pos[i] <= 1; m_we[i] <= we[i]; m_ar[i] <= ar_in[i]; m_ack[i] <= 1'b1;
          end
        end else if (m_pos[i] == acc_len(i, m_we[i])) begin
          m_pos[i] <= 0; m_done[i] <= 1'b1;
        end else begin
          m_pos[i] <= m_pos[i] + 1;
        end
      end
    end
  end

  // Measurement counters for the literal expectations
  int cyc = 0;
  int n_busy [2], n_wl [2], n_pl [2], n_sao [2], n_wb [2], n_din [2], n_pc [2];
  int n_rdvld [2], rdvld_at [2], n_ack [2], n_done [2], last_ack [2], ack_gap [2];

  always @(negedge clk) begin
    logic [11:0] act, exp_v;
    cyc++;
    for (int i = 0; i < 2; i++) begin
      if (chk_en) begin
        exp_v = expect_vec(i);
        act = {ack[i], busy[i], arlat[i], wl[i], pl[i], sa[i], wb[i], din[i], rdvld[i], done[i]};
        checks++;
        if (act === exp_v) passes++;
        else $display("FAIL model_cmp inst%0d t=%0t got %b required %b (ack,busy,ar,wl,pl,sa,wb,din,rdvld,done)",
                      i, $time, act, exp_v);
      end
      if (busy[i]) n_busy[i]++;
      if (wl[i]) n_wl[i]++;
      if (pl[i]) n_pl[i]++;
      if (sa[i] && !wb[i]) n_sao[i]++;
      if (wb[i]) n_wb[i]++;
      if (din[i]) n_din[i]++;
      if (busy[i] && !wl[i]) n_pc[i]++;
      if (rdvld[i]) begin n_rdvld[i]++; rdvld_at[i] = n_busy[i]; end
      if (ack[i]) begin ack_gap[i] = cyc - last_ack[i]; last_ack[i] = cyc; n_ack[i]++; end
      if (done[i]) n_done[i]++;
    end
  end

  task automatic check(input string name, input int act, input int exp_v);
    checks++;
    if (act == exp_v) passes++;
    else $display("FAIL %s: got %0d required %0d", name, act, exp_v);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_meas(input int i);
    n_busy[i] = 0; n_wl[i] = 0; n_pl[i] = 0; n_sao[i] = 0; n_wb[i] = 0; n_din[i] = 0;
    n_pc[i] = 0; n_rdvld[i] = 0; rdvld_at[i] = 0; n_ack[i] = 0; n_done[i] = 0;
  endtask

  task automatic wait_ack(input int i);
    int b = 0;
    step();
    while (!ack[i] && b < 40) begin step(); b++; end
    check("ack_seen", int'(ack[i]), 1);
  endtask

  task automatic start_req(input int i, input logic w, input logic [2:0] a);
    req[i] = 1'b1; we[i] = w; ar_in[i] = a;
    wait_ack(i);
    req[i] = 1'b0;
  endtask

  task automatic wait_done(input int i);
    int b = 0;
    while (!done[i] && b < 60) begin step(); b++; end
    check("done_seen", int'(done[i]), 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; req = 2'b00; we = 2'b00; ar_in[0] = 3'd0; ar_in[1] = 3'd0;
    repeat (2) @(posedge clk);
    #1 chk_en = 1'b1;
    step();
    check("reset_busy", int'(busy[0]), 0);
    check("reset_arlat", int'(arlat[0]), 0);
    rst_n = 1'b1;
    step();

    // Read row 5
    clear_meas(0);
    start_req(0, 1'b0, 3'd5);
    check("rd_arlat", int'(arlat[0]), 5);
    wait_done(0);
    check("rd_busy", n_busy[0], 12);
    check("rd_wl_cycles", n_wl[0], 10);
    check("rd_pl_cycles", n_pl[0], 3);
    check("rd_sense_cycles", n_sao[0], 2);
    check("rd_restore_cycles", n_wb[0], 3);
    check("rd_prech_cycles", n_pc[0], 2);
    check("rd_rdvld_pos", rdvld_at[0], 7);
    check("rd_rdvld_cnt", n_rdvld[0], 1);
    check("rd_dinsel", n_din[0], 0);
    step();

    // Write row 0
    clear_meas(0);
    start_req(0, 1'b1, 3'd0);
    wait_done(0);
    check("wr_busy", n_busy[0], 7);
    check("wr_pl", n_pl[0], 0);
    check("wr_sa", n_sao[0], 0);
    check("wr_wb", n_wb[0], 3);
    check("wr_din", n_din[0], 3);
    check("wr_rdvld", n_rdvld[0], 0);
    step(); step();

    // Back-to-back reads of rows 2 then 7 with request held
    clear_meas(0);
    req[0] = 1'b1; we[0] = 1'b0; ar_in[0] = 3'd2;
    wait_ack(0);
    ar_in[0] = 3'd7;
    check("b2b_arlat_first", int'(arlat[0]), 2);
    wait_done(0);
    check("b2b_arlat_at_done", int'(arlat[0]), 2);
    check("b2b_no_ack_at_done", int'(ack[0]), 0);
    step();
    check("b2b_second_ack", int'(ack[0]), 1);
    check("b2b_ack_gap", ack_gap[0], 13);
    check("b2b_arlat_second", int'(arlat[0]), 7);
    req[0] = 1'b0;
    wait_done(0);
    check("b2b_ack_count", n_ack[0], 2);
    step();

    // Request pulse during SENSE is ignored
    clear_meas(0);
    start_req(0, 1'b0, 3'd3);
    for (int b = 0; b < 20 && !(sa[0] && !wb[0]); b++) step();
    check("sense_reached", int'(sa[0] && !wb[0]), 1);
    req[0] = 1'b1; ar_in[0] = 3'd6;
    step();
    req[0] = 1'b0;
    wait_done(0);
    check("pulse_ack_count", n_ack[0], 1);
    check("pulse_arlat", int'(arlat[0]), 3);
    check("pulse_busy", n_busy[0], 12);
    step();

    // Reset in the middle of PLATE
    clear_meas(0);
    start_req(0, 1'b0, 3'd4);
    for (int b = 0; b < 20 && !pl[0]; b++) step();
    step();
    check("plate_reached", int'(pl[0]), 1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_outputs", int'({busy[0], wl[0], pl[0], sa[0], wb[0], arlat[0]}), 0);
    step(); step();
    rst_n = 1'b1;
    step(); step();
    check("rst_no_done", n_done[0], 0);
    clear_meas(0);
    start_req(0, 1'b1, 3'd1);
    wait_done(0);
    check("post_rst_wr_busy", n_busy[0], 7);
    check("post_rst_arlat", int'(arlat[0]), 1);
    step();

    // All-ones timing instance
    clear_meas(1);
    start_req(1, 1'b0, 3'd5);
    wait_done(1);
    check("t1_rd_busy", n_busy[1], 5);
    check("t1_rd_sense", n_sao[1], 1);
    check("t1_rdvld_pos", rdvld_at[1], 3);
    check("t1_rdvld_cnt", n_rdvld[1], 1);
    clear_meas(1);
    start_req(1, 1'b1, 3'd2);
    wait_done(1);
    check("t1_wr_busy", n_busy[1], 3);
    check("t1_wr_wb", n_wb[1], 1);

    // Random traffic on both instances, checked by the per-cycle model compare
    for (int c = 0; c < 800; c++) begin
      step();
      for (int i = 0; i < 2; i++) begin
        req[i] = ($urandom % 4) != 0;
        we[i] = 1'($urandom);
        ar_in[i] = 3'($urandom);
      end
    end
    req = 2'b00;
    repeat (20) step();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/epl_row_access_ctrl.md
Name: epl_row_access_ctrl

Overview:
Sequencer for one FeRAM row access in the EPLFFRAM02 macro. It accepts a read or write request and latches the 3-bit row address that feeds the row decoder. It then steps the array through the wordline, plate, sense, restore and precharge phases using programmable phase lengths. Reads are destructive, so a read always ends with a restore of the sensed data; a write restores external data instead.

Parameters:
ROW_AW, 3, row address width (matches decoder input `ADDR_AX)
T_WL, 2, cycles in WL_ON phase (>=1)
T_PL, 3, cycles in PLATE phase (>=1)
T_SA, 2, cycles in SENSE phase (>=1)
T_RS, 3, cycles in RESTORE phase (>=1)
T_PC, 2, cycles in PRECH phase (>=1)
CNT_W, 4, phase counter width; must hold max(T_*)-1

Ports:
pClk_i  in  1  clock, rising edge
pRst_n_i  in  1  asynchronous active-low reset
pReq_i  in  1  access request, level; sampled only in IDLE
pWe_i  in  1  1=write, 0=read; sampled with pReq_i
pAr_i  in  ROW_AW  requested row address
pAck_o  out  1  one-cycle pulse: request accepted
pBusy_o  out  1  high whenever state != IDLE
pArLat_o  out  ROW_AW  latched row address to row decoder
pWlEn_o  out  1  wordline enable (gates decoder one-hot output)
pPlEn_o  out  1  plate pulse
pSaEn_o  out  1  sense-amp enable
pWbEn_o  out  1  bitline write-back / restore drive
pDinSel_o  out  1  restore source: 1=external write data, 0=sensed data
pRdVld_o  out  1  one-cycle pulse: sensed read data valid
pDone_o  out  1  one-cycle pulse: access complete, back in IDLE

Behaviour:
- Reset (async, pRst_n_i=0): state=IDLE, counter=0, weLat=0, every output 0 including pArLat_o. All array enables drop immediately, including mid-access. After release the block waits in IDLE. The interrupted access is lost and is neither acked again nor completed.
- States: IDLE, WL_ON, PLATE, SENSE, RESTORE, PRECH. The state register and counter are updated on the rising edge. Outputs are decoded from registered state only, so they are glitch-free.
- Accept: at an edge with state=IDLE and pReq_i=1, the block:
  - loads pArLat_o<=pAr_i and weLat<=pWe_i;
  - sets pAck_o<=1 for one cycle;
  - moves to WL_ON and loads counter<=T_WL-1.
- pReq_i is ignored in every state other than IDLE. There is no ack and no queuing; the requester must hold pReq_i until it sees pAck_o.
- Phase advance: on each edge the counter decrements. When counter=0, the block moves to the next state and reloads that state's T_x-1.
- Read path: WL_ON -> PLATE -> SENSE -> RESTORE -> PRECH -> IDLE.
- Write path: WL_ON -> RESTORE -> PRECH -> IDLE (PLATE and SENSE are skipped).
- Busy length: read = T_WL+T_PL+T_SA+T_RS+T_PC cycles (default 12); write = T_WL+T_RS+T_PC (default 7).
- Output decode:
  - pWlEn_o=1 in WL_ON, PLATE, SENSE, RESTORE.
  - pPlEn_o=1 in PLATE.
  - pSaEn_o=1 in SENSE and RESTORE.
  - pWbEn_o=1 in RESTORE.
  - pDinSel_o=weLat in RESTORE, else 0.
  - pBusy_o=1 when state!=IDLE.
- pRdVld_o=1 only in the last SENSE cycle (counter=0).
- pDone_o is a registered one-cycle pulse in the first IDLE cycle after PRECH.
- pArLat_o holds its value from accept until the next accept; it does not change during an access or in IDLE.
- Back-to-back: if pReq_i stays high, the next request is accepted on the edge ending the pDone_o cycle. pDone_o and the next pAck_o are therefore never in the same cycle, and the minimum period is busy+1 cycles.
- Any T_x=1 gives a single-cycle phase. Values of 0 are illegal; the implementation flags them with a simulation-time assertion.
- No simultaneous-event conflicts exist beyond reset, because requests are sampled only in IDLE.

Test Plan:
1. Reset, then read row 5 with default params: pReq_i=1, pWe_i=0, pAr_i=3'd5. Expect pAck_o the cycle after accept, pArLat_o=5, and pBusy_o high for 12 cycles. Expect phase lengths wl=2, pl=3, sa=2, rs=3, pc=2. Expect pRdVld_o in busy cycle 7, pDinSel_o=0 in RESTORE, then pDone_o.
2. Write row 0: pWe_i=1, pAr_i=0. Expect 7 busy cycles, pPlEn_o and pSaEn_o never high, pWbEn_o and pDinSel_o high for 3 cycles, no pRdVld_o.
3. Hold pReq_i high with rows 2 then 7. Expect exactly one idle cycle (the pDone_o cycle) between accesses, second pAck_o 13 cycles after the first, and pArLat_o switching 2->7 only at the second accept.
4. Pulse pReq_i for 1 cycle in the middle of SENSE. Expect no pAck_o, no state change, and pArLat_o unchanged.
5. Assert pRst_n_i low in the middle of PLATE of a read. Expect all enables and pArLat_o at 0 immediately, with no pDone_o. After release, a new write request runs normally.
6. Set all T_x=1: read busy = 5 cycles and write busy = 3 cycles. pRdVld_o is coincident with the single SENSE cycle.
